// File: rtl/swo_pkg.sv
// Shared types, default parameters and timing helpers for the SWO Manchester receiver.
package swo_pkg;

    // Receiver states: waiting for a start bit, measuring its first half, decoding data bits.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_HBLEN = 2'd1,
        ST_BITS  = 2'd2
    } swo_state_e;

    localparam int DEF_CNT_W         = 17;
    localparam int DEF_DATA_W        = 8;
    localparam int DEF_TOL           = 2;
    localparam int DEF_TIMEOUT_SHIFT = 3;
    localparam int DEF_SYNC_STAGES   = 2;
    localparam int DEF_MIN_HB        = 2;

    // Width used for threshold/timeout arithmetic. It exceeds CNT_W+TIMEOUT_SHIFT+1
    // for every sensible configuration, so neither doubling nor shifting hb_len
    // can lose bits.
    localparam int CALC_W = 64;

    // Earliest counter value at which an edge counts as a mid-bit transition:
    // 2*hb - tol, clamped to 1 when the subtraction would reach zero or below.
    function automatic logic [CALC_W-1:0] mid_threshold(
        input logic [CALC_W-1:0] hb,
        input logic [CALC_W-1:0] tol
    );
        logic [CALC_W-1:0] twice;
        twice = hb << 1;
        if (twice <= tol) begin
            return {{(CALC_W-1){1'b0}}, 1'b1};
        end else begin
            return twice - tol;
        end
    endfunction

    // Counter value beyond which a silent line ends the packet.
    function automatic logic [CALC_W-1:0] timeout_limit(
        input logic [CALC_W-1:0] hb,
        input int unsigned       shift
    );
        return hb << shift;
    endfunction

endpackage

// File: rtl/swo_edge_sync.sv
// Input synchroniser for the raw SWO pin plus one-cycle history for edge detection.
module swo_edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic din_i,
    output logic s_o,
    output logic prev_o,
    output logic edge_o,
    output logic rise_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    // Shift the asynchronous pin through the synchroniser and keep last cycle's level.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q <= {SYNC_STAGES{1'b0}};
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], din_i};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign s_o    = sync_q[SYNC_STAGES-1];
    assign prev_o = prev_q;
    assign edge_o = sync_q[SYNC_STAGES-1] ^ prev_q;
    assign rise_o = (sync_q[SYNC_STAGES-1] ^ prev_q) & sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/swo_manch_rx.sv
// Manchester SWO receiver: measures the half-bit from each start bit, decodes
// mid-bit transitions into DATA_W-bit words (LSB first) and flags truncated words.
module swo_manch_rx
    import swo_pkg::*;
#(
    parameter int CNT_W         = DEF_CNT_W,
    parameter int DATA_W        = DEF_DATA_W,
    parameter int TOL           = DEF_TOL,
    parameter int TIMEOUT_SHIFT = DEF_TIMEOUT_SHIFT,
    parameter int SYNC_STAGES   = DEF_SYNC_STAGES,
    parameter int MIN_HB        = DEF_MIN_HB
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              enable_i,
    input  logic              swo_in_i,
    output logic              word_valid_o,
    output logic [DATA_W-1:0] word_data_o,
    output logic              word_toggle_o,
    output logic              partial_err_o,
    output logic [CNT_W-1:0]  hb_len_o,
    output logic              busy_o
);

    localparam int               IDX_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_MIN  = CNT_W'(MIN_HB);
    localparam logic [IDX_W-1:0] IDX_ZERO = {IDX_W{1'b0}};
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);

    // Synchronised line view
    logic line_s;
    logic prev_s;
    logic edge_s;
    logic rise_s;
    logic fall_s;

    // State and datapath registers
    swo_state_e        state_q,       state_d;
    logic [CNT_W-1:0]  cnt_q,         cnt_d;
    logic [CNT_W-1:0]  hb_len_q,      hb_len_d;
    logic [IDX_W-1:0]  bit_idx_q,     bit_idx_d;
    logic [DATA_W-1:0] shift_q,       shift_d;
    logic              done_q,        done_d;
    logic              word_valid_q,  word_valid_d;
    logic [DATA_W-1:0] word_data_q,   word_data_d;
    logic              word_toggle_q, word_toggle_d;
    logic              partial_err_q, partial_err_d;

    // Timing arithmetic
    logic [CALC_W-1:0] cnt_wide_s;
    logic [CALC_W-1:0] hb_wide_s;
    logic [CALC_W-1:0] thresh_s;
    logic [CALC_W-1:0] tmo_s;
    logic [CNT_W-1:0]  cnt_inc_s;
    logic              mid_bit_s;
    logic              timeout_s;

    swo_edge_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_edge_sync (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .din_i  (swo_in_i),
        .s_o    (line_s),
        .prev_o (prev_s),
        .edge_o (edge_s),
        .rise_o (rise_s)
    );

    // The start bit's measured half always ends on a falling edge.
    assign fall_s     = edge_s & ~line_s;

    assign cnt_wide_s = CALC_W'(cnt_q);
    assign hb_wide_s  = CALC_W'(hb_len_q);
    assign thresh_s   = mid_threshold(hb_wide_s, CALC_W'(TOL));
    assign tmo_s      = timeout_limit(hb_wide_s, TIMEOUT_SHIFT);
    assign cnt_inc_s  = (cnt_q == CNT_MAX) ? cnt_q : (cnt_q + CNT_ONE);
    assign mid_bit_s  = edge_s && (cnt_wide_s >= thresh_s);
    assign timeout_s  = !edge_s && (cnt_wide_s > tmo_s);

    // Next-state, counter, shift-register and output strobe logic.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        hb_len_d      = hb_len_q;
        bit_idx_d     = bit_idx_q;
        shift_d       = shift_q;
        done_d        = 1'b0;
        word_valid_d  = 1'b0;
        word_data_d   = word_data_q;
        word_toggle_d = word_toggle_q;
        partial_err_d = 1'b0;

        if (!enable_i) begin
            // Disabled: drop any packet in flight silently, including a word
            // that completed last cycle but has not been presented yet.
            state_d   = ST_IDLE;
            cnt_d     = CNT_ONE;
            bit_idx_d = IDX_ZERO;
        end else begin
            // A word completed last cycle: present it together with the toggle.
            if (done_q) begin
                word_valid_d  = 1'b1;
                word_data_d   = shift_q;
                word_toggle_d = ~word_toggle_q;
            end else begin
                word_valid_d  = 1'b0;
            end

            case (state_q)
                ST_IDLE: begin
                    cnt_d = CNT_ONE;
                    if (rise_s) begin
                        state_d = ST_HBLEN;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end

                ST_HBLEN: begin
                    if (fall_s) begin
                        if (cnt_q < CNT_MIN) begin
                            // Too short to be a real half-bit: treat as a glitch.
                            state_d = ST_IDLE;
                            cnt_d   = CNT_ONE;
                        end else begin
                            hb_len_d  = cnt_q;
                            cnt_d     = CNT_ONE;
                            bit_idx_d = IDX_ZERO;
                            state_d   = ST_BITS;
                        end
                    end else if (cnt_q == CNT_MAX) begin
                        state_d = ST_IDLE;
                        cnt_d   = CNT_ONE;
                    end else begin
                        cnt_d = cnt_inc_s;
                    end
                end

                ST_BITS: begin
                    if (mid_bit_s) begin
                        // Bit value is the level before the mid-bit transition.
                        shift_d[bit_idx_q] = prev_s;
                        cnt_d              = CNT_ONE;
                        if (bit_idx_q == IDX_LAST) begin
                            bit_idx_d = IDX_ZERO;
                            done_d    = 1'b1;
                        end else begin
                            bit_idx_d = bit_idx_q + IDX_ONE;
                        end
                    end else if (timeout_s) begin
                        state_d       = ST_IDLE;
                        cnt_d         = CNT_ONE;
                        partial_err_d = (bit_idx_q != IDX_ZERO);
                        bit_idx_d     = IDX_ZERO;
                    end else begin
                        // Bit-boundary edges fall through here and do not restart timing.
                        cnt_d = cnt_inc_s;
                    end
                end

                default: begin
                    state_d   = ST_IDLE;
                    cnt_d     = CNT_ONE;
                    bit_idx_d = IDX_ZERO;
                end
            endcase
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= ST_IDLE;
            cnt_q         <= CNT_ONE;
            hb_len_q      <= {CNT_W{1'b0}};
            bit_idx_q     <= IDX_ZERO;
            shift_q       <= {DATA_W{1'b0}};
            done_q        <= 1'b0;
            word_valid_q  <= 1'b0;
            word_data_q   <= {DATA_W{1'b0}};
            word_toggle_q <= 1'b0;
            partial_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            hb_len_q      <= hb_len_d;
            bit_idx_q     <= bit_idx_d;
            shift_q       <= shift_d;
            done_q        <= done_d;
            word_valid_q  <= word_valid_d;
            word_data_q   <= word_data_d;
            word_toggle_q <= word_toggle_d;
            partial_err_q <= partial_err_d;
        end
    end

    assign word_valid_o  = word_valid_q;
    assign word_data_o   = word_data_q;
    assign word_toggle_o = word_toggle_q;
    assign partial_err_o = partial_err_q;
    assign hb_len_o      = hb_len_q;
    assign busy_o        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_swo_manch_rx.sv
// Directed self-checking bench for swo_manch_rx at half-bit = 10 clocks.
module tb_swo_manch_rx;

    localparam int HB    = 10;
    localparam int SYNC  = 2;
    localparam int DW    = 8;
    localparam int CW    = 17;

    logic          clk = 1'b0;
    logic          rst;
    logic          enable;
    logic          swo;
    logic          word_valid;
    logic [DW-1:0] word_data;
    logic          word_toggle;
    logic          partial_err;
    logic [CW-1:0] hb_len;
    logic          busy;

    swo_manch_rx dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .enable_i      (enable),
        .swo_in_i      (swo),
        .word_valid_o  (word_valid),
        .word_data_o   (word_data),
        .word_toggle_o (word_toggle),
        .partial_err_o (partial_err),
        .hb_len_o      (hb_len),
        .busy_o        (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    // Strobe monitor, sampled on the falling edge
    int          nvalid = 0;
    int          nperr  = 0;
    logic [31:0] val_data [64];
    int          val_cyc  [64];

    always @(negedge clk) begin
        if (word_valid === 1'b1) begin
            if (nvalid < 64) begin
                val_data[nvalid] <= 32'(word_data);
                val_cyc[nvalid]  <= cyc;
            end
            nvalid <= nvalid + 1;
        end
        if (partial_err === 1'b1) nperr <= nperr + 1;
    end

    int mid_cyc = 0;
    int b_v;
    int b_p;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Hold the line at a level for n clocks; always entered and left on a falling edge.
    task automatic drive(input logic lvl, input int n);
        swo = lvl;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_start();
        drive(1'b1, HB);
        drive(1'b0, HB);
    endtask

    task automatic send_bit(input logic b);
        drive(b, HB);
        mid_cyc = cyc;
        drive(~b, HB);
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < DW; i++) send_bit(w[i]);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic check_all_zero(input string pfx);
        check_eq({pfx, "_valid"},  32'(word_valid),  32'd0);
        check_eq({pfx, "_data"},   32'(word_data),   32'd0);
        check_eq({pfx, "_toggle"}, 32'(word_toggle), 32'd0);
        check_eq({pfx, "_perr"},   32'(partial_err), 32'd0);
        check_eq({pfx, "_hblen"},  32'(hb_len),      32'd0);
        check_eq({pfx, "_busy"},   32'(busy),        32'd0);
    endtask

    initial begin
        rst    = 1'b1;
        enable = 1'b1;
        swo    = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check_all_zero("reset");

        // Basic word 0xA5
        b_v = nvalid; b_p = nperr;
        send_start();
        send_word(32'h0000_00A5);
        check_eq("basic_count",   32'(nvalid - b_v), 32'd1);
        check_eq("basic_data",    val_data[b_v], 32'h0000_00A5);
        check_eq("basic_toggle",  32'(word_toggle), 32'd1);
        check_eq("basic_hblen",   32'(hb_len), 32'd10);
        check_eq("basic_latency", 32'(val_cyc[b_v] - mid_cyc), 32'(SYNC + 2));
        drive(1'b0, 100);
        check_eq("basic_idle_busy", 32'(busy), 32'd0);
        check_eq("basic_no_perr",   32'(nperr - b_p), 32'd0);

        // Glitch: one-clock pulse
        b_v = nvalid; b_p = nperr;
        drive(1'b1, 1);
        drive(1'b0, 30);
        check_eq("glitch_busy",  32'(busy), 32'd0);
        check_eq("glitch_hblen", 32'(hb_len), 32'd10);
        check_eq("glitch_valid", 32'(nvalid - b_v), 32'd0);
        check_eq("glitch_perr",  32'(nperr - b_p), 32'd0);

        // Back-to-back words after a fresh reset
        do_reset();
        b_v = nvalid; b_p = nperr;
        send_start();
        send_word(32'h0000_003C);
        send_word(32'h0000_00FF);
        check_eq("b2b_count",   32'(nvalid - b_v), 32'd2);
        check_eq("b2b_data0",   val_data[b_v], 32'h0000_003C);
        check_eq("b2b_data1",   val_data[b_v + 1], 32'h0000_00FF);
        check_eq("b2b_spacing", 32'(val_cyc[b_v + 1] - val_cyc[b_v]), 32'(16 * HB));
        check_eq("b2b_toggle",  32'(word_toggle), 32'd0);
        drive(1'b0, 100);

        // Timeout with three pending bits
        b_v = nvalid; b_p = nperr;
        send_start();
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        check_eq("tmo_busy_before", 32'(busy), 32'd1);
        drive(1'b0, 120);
        check_eq("tmo_perr",       32'(nperr - b_p), 32'd1);
        check_eq("tmo_valid",      32'(nvalid - b_v), 32'd0);
        check_eq("tmo_busy_after", 32'(busy), 32'd0);

        // Tolerance boundary: edge at count 17 ignored, edge at 18 is bit0 = 1
        b_v = nvalid; b_p = nperr;
        drive(1'b1, HB);
        drive(1'b0, 17);
        drive(1'b1, 1);
        drive(1'b0, HB);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        check_eq("tol_count", 32'(nvalid - b_v), 32'd1);
        check_eq("tol_data",  val_data[b_v], 32'h0000_00B3);
        check_eq("tol_hblen", 32'(hb_len), 32'd10);
        drive(1'b0, 100);

        // Reset in the middle of a word
        b_v = nvalid; b_p = nperr;
        send_start();
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b0);
        send_bit(1'b1);
        rst = 1'b1;
        drive(1'b0, 1);
        check_all_zero("midrst");
        rst = 1'b0;
        drive(1'b0, 120);
        check_eq("midrst_perr",  32'(nperr - b_p), 32'd0);
        check_eq("midrst_valid", 32'(nvalid - b_v), 32'd0);

        // Enable dropped in the middle of a word
        b_v = nvalid; b_p = nperr;
        send_start();
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b0);
        send_bit(1'b1);
        check_eq("en_busy_before", 32'(busy), 32'd1);
        enable = 1'b0;
        drive(1'b0, 1);
        check_eq("en_busy_off", 32'(busy), 32'd0);
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b1);
        enable = 1'b1;
        drive(1'b0, 120);
        check_eq("en_valid", 32'(nvalid - b_v), 32'd0);
        check_eq("en_perr",  32'(nperr - b_p), 32'd0);
        check_eq("en_busy",  32'(busy), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
